// File: rtl/br_mem_if.sv
// br_mem_if: buffer-register / memory bus interface feeding the ALU BR_in.
// Fetches an operand from data memory into BR, or writes the accumulator
// back to memory, over a four-phase mem_req/mem_ack handshake. Only one
// transfer is outstanding at a time, and all outputs are registered.
// Optional feature macro: BR_TIMEOUT_EN. When it is defined, a wait counter
// aborts a request that gets no ack within TIMEOUT_CYC cycles and raises a
// sticky err flag.
module br_mem_if #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_start,
  input  logic              wr_start,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] acc_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] BR_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACK_LOW = 2'd2
  } state_e;

  state_e              state_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   br_q;
  logic                busy_q;
  logic                done_q;

`ifdef BR_TIMEOUT_EN
  // Counter value on the edge where the TIMEOUT_CYC-th unacknowledged
  // request cycle ends.
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC - 1);
  logic [7:0]          wait_cnt_q;
  logic                err_q;
`endif

  // Handshake FSM: the state and every registered output are updated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      br_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef BR_TIMEOUT_EN
      wait_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A read beats a write that arrives on the same cycle; the write is
          // dropped. mem_ack seen here is ignored.
          if (rd_start) begin
            mem_addr_q <= addr_in;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_REQ;
`ifdef BR_TIMEOUT_EN
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
`endif
          end else if (wr_start) begin
            mem_addr_q  <= addr_in;
            mem_wdata_q <= acc_in;
            mem_we_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_REQ;
`ifdef BR_TIMEOUT_EN
            wait_cnt_q  <= 8'd0;
            err_q       <= 1'b0;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_REQ: begin
          // The first REQ cycle only raises mem_req. An ack is honoured only
          // once the request is actually visible on the bus.
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (mem_ack) begin
            if (!mem_we_q) begin
              br_q <= mem_rdata;
            end else begin
              br_q <= br_q;
            end
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_ACK_LOW;
`ifdef BR_TIMEOUT_EN
          end else if (wait_cnt_q == TO_LIM) begin
            // Abandon the request. The ack phase is skipped and BR is left as is.
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`else
          end else begin
            mem_req_q <= 1'b1;
          end
`endif
        end

        ST_ACK_LOW: begin
          // Four-phase return-to-zero: wait for memory to release mem_ack.
          if (!mem_ack) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_ACK_LOW;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign BR_out    = br_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef BR_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_br_mem_if.sv
// Self-checking bench for br_mem_if. It runs directed and random read/write
// transactions against a transaction-level model made of a memory array plus
// the expected BR and latched-bus values.
module tb_br_mem_if;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rd_start = 1'b0;
  logic          wr_start = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] acc_in = '0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] BR_out;
  logic          busy;
  logic          done;
  logic          err;

  br_mem_if #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rd_start(rd_start), .wr_start(wr_start),
    .addr_in(addr_in), .acc_in(acc_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .BR_out(BR_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference state: memory contents and the values the bus should hold.
  logic [DW-1:0] mem_m [256];
  logic [DW-1:0] exp_br;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic          exp_we;
  int            n_checks = 0;
  int            n_errors = 0;
  int            done_cnt = 0;

  // Count done pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // kind: 0 = read, 1 = write, 2 = read and write started together.
  task automatic do_op(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int dly, input int hold, input bit poke);
    int lat;
    int d0;
    bit is_rd;
    is_rd = (kind != 1);
    d0 = done_cnt;
    @(negedge clk);
    rd_start = (kind != 1);
    wr_start = (kind != 0);
    addr_in  = a;
    acc_in   = d;
    @(negedge clk);
    rd_start = poke;
    wr_start = poke;
    addr_in  = ~a;
    acc_in   = ~d;
    exp_addr = a;
    exp_we   = !is_rd;
    if (!is_rd) exp_wdata = d;
    check("busy_accept", {31'd0, busy}, 32'd1);
    check("req_first_cycle", {31'd0, mem_req}, 32'd0);
    check("err_cleared", {31'd0, err}, 32'd0);
    lat = 1;
    while (mem_req !== 1'b1 && lat < 5) begin
      @(negedge clk);
      rd_start = 1'b0;
      wr_start = 1'b0;
      lat++;
    end
    rd_start = 1'b0;
    wr_start = 1'b0;
    check("req_latency", lat, 32'd2);
    check("mem_addr", {24'd0, mem_addr}, {24'd0, exp_addr});
    check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
    check("mem_wdata", {16'd0, mem_wdata}, {16'd0, exp_wdata});
    repeat (dly) @(negedge clk);
    check("req_held", {31'd0, mem_req}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = is_rd ? mem_m[a] : DW'($urandom);
    @(negedge clk);
    if (is_rd) exp_br = mem_m[a];
    else mem_m[a] = d;
    mem_rdata = DW'($urandom);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("req_dropped", {31'd0, mem_req}, 32'd0);
    check("br_out", {16'd0, BR_out}, {16'd0, exp_br});
    for (int i = 0; i < hold; i++) begin
      rd_start = poke;
      addr_in  = ~a;
      @(negedge clk);
      check("busy_ack_held", {31'd0, busy}, 32'd1);
      check("no_req_ack_held", {31'd0, mem_req}, 32'd0);
    end
    rd_start = 1'b0;
    mem_ack  = 1'b0;
    @(negedge clk);
    check("idle_after_ack", {31'd0, busy}, 32'd0);
    check("done_count", done_cnt - d0, 32'd1);
    check("addr_kept", {24'd0, mem_addr}, {24'd0, exp_addr});
    check("br_kept", {16'd0, BR_out}, {16'd0, exp_br});
  endtask

`ifdef BR_TIMEOUT_EN
  // Start a read that is never acknowledged and measure how long it waits.
  task automatic do_timeout(input logic [AW-1:0] a);
    int n;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    rd_start = 1'b1;
    addr_in  = a;
    @(negedge clk);
    rd_start = 1'b0;
    exp_addr = a;
    exp_we   = 1'b0;
    @(negedge clk);
    check("to_req_up", {31'd0, mem_req}, 32'd1);
    n = 0;
    while (mem_req === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("to_req_cycles", n, TO);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_done", {31'd0, done}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_br", {16'd0, BR_out}, {16'd0, exp_br});
    @(negedge clk);
    check("to_err_sticky", {31'd0, err}, 32'd1);
    check("to_done_count", done_cnt - d0, 32'd1);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = DW'($urandom);
    mem_m[8'h12] = 16'hBEEF;
    mem_m[8'h05] = 16'h1234;
    exp_br = '0; exp_addr = '0; exp_wdata = '0; exp_we = 1'b0;

    // Asynchronous reset must clear every output without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_br", {16'd0, BR_out}, 32'd0);
    check("rst_bus", {mem_we, 7'd0, mem_addr, mem_wdata}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(0, 8'h12, 16'h0000, 2, 0, 1'b0);        // read into BR
    do_op(1, 8'h34, 16'h0F0F, 1, 0, 1'b0);        // write leaves BR alone
    do_op(2, 8'h05, 16'hAAAA, 0, 1, 1'b1);        // read wins, restart ignored
    do_op(0, 8'h34, 16'h0000, 1, 4, 1'b1);        // ack held 4 cycles
`ifndef BR_TIMEOUT_EN
    do_op(0, 8'h77, 16'h0000, 20, 0, 1'b0);       // no timeout: waits forever
`endif

    // An ack arriving while idle must have no effect.
    begin
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      mem_ack = 1'b1;
      mem_rdata = 16'hDEAD;
      repeat (2) @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      check("idle_ack_busy", {31'd0, busy}, 32'd0);
      check("idle_ack_done", done_cnt - d0, 32'd0);
      check("idle_ack_br", {16'd0, BR_out}, {16'd0, exp_br});
    end

`ifdef BR_TIMEOUT_EN
    do_timeout(8'h44);
    do_op(0, 8'h12, 16'h0000, 0, 0, 1'b0);        // next start clears err
`endif

    for (int t = 0; t < 40; t++) begin
      do_op(int'($urandom_range(0, 2)), AW'($urandom), DW'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
      check("err_low", {31'd0, err}, 32'd0);
    end

    // Reset in the middle of a request drops mem_req and BR at once.
    begin
      int d0;
      @(negedge clk);
      rd_start = 1'b1;
      addr_in  = 8'h21;
      @(negedge clk);
      rd_start = 1'b0;
      @(negedge clk);
      check("pre_rst_req", {31'd0, mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_req", {31'd0, mem_req}, 32'd0);
      check("mid_rst_br", {16'd0, BR_out}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      d0 = done_cnt;
      repeat (4) @(negedge clk);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_req", {31'd0, mem_req}, 32'd0);
      check("post_rst_done", done_cnt - d0, 32'd0);
      exp_br = '0; exp_addr = '0; exp_wdata = '0;
      do_op(0, 8'h05, 16'h0000, 1, 1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
